// File: rtl/pe_pkg.sv
// Shared types for the sparse PE datapath.
//   ia_data_t   : signed 16-bit activation value
//   c_idx_t     : 5-bit channel index of an activation
//   ia_pair_t   : one compressed IA entry {data, c_idx, last}
//   enc_state_e : state encoding of the IA sparse encoder FSM
//   IA_CHANNEL, IA_ROW : PE array geometry constants
package pe_pkg;

  localparam int IA_CHANNEL = 8;
  localparam int IA_ROW     = 16;

  typedef logic signed [15:0] ia_data_t;
  typedef logic [4:0]         c_idx_t;

  typedef struct packed {
    ia_data_t data;
    c_idx_t   c_idx;
    logic     last;
  } ia_pair_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_FLUSH,
    S_DRAIN
  } enc_state_e;

endpackage

// File: rtl/ia_pair_fifo.sv
// First-word-fall-through FIFO of ia_pair_t entries.
// Ports:
//   i_clk, i_rst       : clock, asynchronous active-high reset
//   i_push, i_wdata    : write request and entry
//   o_full             : no free slot (a push is still taken if a pop happens the same cycle)
//   i_pop              : consume head entry (ignored while empty)
//   o_rdata            : head entry, forced to zero while empty
//   o_empty            : no entry stored
// DEPTH must be a power of two >= 2.
module ia_pair_fifo
  import pe_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic     i_clk,
  input  logic     i_rst,
  input  logic     i_push,
  input  ia_pair_t i_wdata,
  output logic     o_full,
  input  logic     i_pop,
  output ia_pair_t o_rdata,
  output logic     o_empty
);

  localparam int AW = $clog2(DEPTH);

  ia_pair_t       r_mem [DEPTH];
  // Extra MSB on each pointer tells full (MSBs differ) from empty (MSBs equal).
  logic [AW:0]    r_wr_ptr;
  logic [AW:0]    r_rd_ptr;
  logic           w_do_push;
  logic           w_do_pop;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: the read port is masked while empty.
  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
  end

  assign o_rdata = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/ia_sparse_encoder.sv
// Dense-to-sparse IA encoder: accepts N_ELEM signed activations per frame,
// drops zeros and emits (data, c_idx, last) pairs in channel order through an
// FWFT output FIFO; reports the non-zero count when the frame has drained.
// Optional build macro: IA_PRUNE_EN -- treat |data| <= ZERO_THRESH as zero
// (magnitude of the most negative value saturates to the most positive).
// Ports:
//   i_clk, i_rst                       : clock, async active-high reset
//   i_start                            : frame start, honoured only in IDLE
//   i_in_valid/o_in_ready/i_in_data    : dense element input
//   o_out_valid/i_out_ready            : pair output handshake
//   o_out_data/o_out_c_idx/o_out_last  : pair payload
//   o_busy                             : FSM not IDLE
//   o_done                             : one-cycle pulse once the frame has drained
//   o_nnz_len/o_all_zero               : frame summary, valid from o_done to next start
//   o_state                            : current FSM state (observation only)
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; a valid source holds its payload until that edge.
module ia_sparse_encoder
  import pe_pkg::*;
#(
  parameter int N_ELEM      = 32,
  parameter int DATA_W      = 16,
  parameter int FIFO_DEPTH  = 8,
  parameter int ZERO_THRESH = 0
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_start,
  input  logic                           i_in_valid,
  output logic                           o_in_ready,
  input  logic signed [DATA_W-1:0]       i_in_data,
  output logic                           o_out_valid,
  input  logic                           i_out_ready,
  output logic signed [DATA_W-1:0]       o_out_data,
  output logic [$clog2(N_ELEM)-1:0]      o_out_c_idx,
  output logic                           o_out_last,
  output logic                           o_busy,
  output logic                           o_done,
  output logic [$clog2(N_ELEM+1)-1:0]    o_nnz_len,
  output logic                           o_all_zero,
  output enc_state_e                     o_state
);

  localparam int IDX_W = $clog2(N_ELEM);
  localparam int CNT_W = $clog2(N_ELEM + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ELEM - 1);
`ifdef IA_PRUNE_EN
  localparam int THRESH = ZERO_THRESH;
`else
  localparam int THRESH = 0;
`endif

  enc_state_e                 r_state;
  enc_state_e                 w_next_state;
  logic [IDX_W-1:0]           r_elem_cnt;
  logic [CNT_W-1:0]           r_nnz_cnt;
  logic signed [DATA_W-1:0]   r_pend_data;
  logic [IDX_W-1:0]           r_pend_idx;
  logic                       r_pend_vld;
  logic [CNT_W-1:0]           r_nnz_len;
  logic                       r_all_zero;
  logic                       r_done;

  logic [DATA_W-1:0]          w_mag;
  logic                       w_is_nz;
  logic                       w_accept;
  logic                       w_push;
  logic                       w_push_last;
  logic                       w_full;
  logic                       w_empty;
  ia_pair_t                   w_push_pair;
  ia_pair_t                   w_pop_pair;

  // Saturating magnitude; with THRESH == 0 this reduces to a plain data != 0 test.
  always_comb begin
    w_mag = i_in_data;
    if (i_in_data == {1'b1, {(DATA_W-1){1'b0}}}) w_mag = {1'b0, {(DATA_W-1){1'b1}}};
    else if (i_in_data < 0)                      w_mag = -i_in_data;
  end
  assign w_is_nz  = (32'(w_mag) > 32'(THRESH));

  assign w_accept = (r_state == S_SCAN) && i_in_valid && !w_full;

  always_comb begin
    w_next_state = r_state;
    w_push       = 1'b0;
    w_push_last  = 1'b0;
    unique case (r_state)
      S_IDLE: if (i_start) w_next_state = S_SCAN;
      S_SCAN: begin
        // The held pair is only known not to be last once a later non-zero arrives.
        if (w_accept && w_is_nz && r_pend_vld) w_push = 1'b1;
        if (w_accept && (r_elem_cnt == LAST_IDX)) w_next_state = S_FLUSH;
      end
      S_FLUSH: begin
        if (!r_pend_vld) begin
          w_next_state = S_DRAIN;
        end else if (!w_full) begin
          w_push       = 1'b1;
          w_push_last  = 1'b1;
          w_next_state = S_DRAIN;
        end
      end
      S_DRAIN: if (w_empty) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_elem_cnt  <= '0;
      r_nnz_cnt   <= '0;
      r_pend_data <= '0;
      r_pend_idx  <= '0;
      r_pend_vld  <= 1'b0;
      r_nnz_len   <= '0;
      r_all_zero  <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_done  <= 1'b0;
      if ((r_state == S_IDLE) && i_start) begin
        r_elem_cnt <= '0;
        r_nnz_cnt  <= '0;
        r_pend_vld <= 1'b0;
        r_nnz_len  <= '0;
        r_all_zero <= 1'b0;
      end
      if (w_accept) begin
        r_elem_cnt <= (r_elem_cnt == LAST_IDX) ? '0 : r_elem_cnt + 1'b1;
        if (w_is_nz) begin
          r_pend_data <= i_in_data;
          r_pend_idx  <= r_elem_cnt;
          r_pend_vld  <= 1'b1;
          r_nnz_cnt   <= r_nnz_cnt + 1'b1;
        end
      end
      if ((r_state == S_FLUSH) && r_pend_vld && !w_full) r_pend_vld <= 1'b0;
      if ((r_state == S_DRAIN) && w_empty) begin
        r_done     <= 1'b1;
        r_nnz_len  <= r_nnz_cnt;
        r_all_zero <= (r_nnz_cnt == '0);
      end
    end
  end

  assign w_push_pair = '{data: r_pend_data, c_idx: r_pend_idx, last: w_push_last};

  ia_pair_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (w_push),
    .i_wdata (w_push_pair),
    .o_full  (w_full),
    .i_pop   (i_out_ready),
    .o_rdata (w_pop_pair),
    .o_empty (w_empty)
  );

  assign o_in_ready  = (r_state == S_SCAN) && !w_full;
  assign o_out_valid = !w_empty;
  assign o_out_data  = w_pop_pair.data;
  assign o_out_c_idx = w_pop_pair.c_idx;
  assign o_out_last  = w_pop_pair.last;
  assign o_busy      = (r_state != S_IDLE);
  assign o_done      = r_done;
  assign o_nnz_len   = r_nnz_len;
  assign o_all_zero  = r_all_zero;
  assign o_state     = r_state;

endmodule
